// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth power-up command path.
// No logic; constants and types only.
// Used by the command FIFO and the authorization block.
package bt_pkg;

  localparam logic [7:0] CMD_G = 8'h67;
  localparam logic [7:0] CMD_S = 8'h73;

  typedef enum logic {IDLE, WAIT_LO} ingress_state_t;

  // True for the two bytes the authorization block acts on
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_G) || (b == CMD_S);
  endfunction

endpackage

// File: rtl/bt_cmd_fifo_if.sv
// Byte handshake bundle: UART receiver side, consumer side, and status.
// Combinational wiring only, no latency.
// Both handshakes are rdy/data with a one-cycle clear pulse from the reader.
interface bt_cmd_fifo_if;

  logic       uart_rdy;
  logic [7:0] uart_data;
  logic       uart_clr_rdy;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;
  logic       flush;
  logic       ovfl;
  logic [7:0] drop_cnt;

  // Drives the UART byte stream and consumes the queued bytes
  modport master (
    output uart_rdy, uart_data, clr_rx_rdy, flush,
    input  uart_clr_rdy, rx_rdy, rx_data, ovfl, drop_cnt
  );

  // The command FIFO itself
  modport slave (
    input  uart_rdy, uart_data, clr_rx_rdy, flush,
    output uart_clr_rdy, rx_rdy, rx_data, ovfl, drop_cnt
  );

endinterface

// File: rtl/bt_fifo_core.sv
// Circular buffer with push/pop/flush and full/empty status.
// Push visible at dout/empty right after the push edge.
// Push while full only succeeds with a same-cycle pop; pop while empty is ignored.
module bt_fifo_core #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // An empty FIFO has nothing to pop even if a push lands this cycle
  assign pop_ok  = pop && !empty;
  // A full FIFO accepts a push only when a pop frees a slot the same cycle
  assign push_ok = push && (!full || pop_ok);
  assign ovf     = push && !push_ok;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/bt_cmd_fifo.sv
// Command buffer between UART receiver and authorization block, with byte filter.
// Captured byte appears at rx_rdy/rx_data right after the capture edge.
// Full FIFO drops the new byte and sets sticky ovfl; the UART is always cleared.
module bt_cmd_fifo
  import bt_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int FILTER_EN = 1
) (
  input logic            clk,
  input logic            rst,
  bt_cmd_fifo_if.slave   bus
);

  ingress_state_t state;
  ingress_state_t next_state;
  logic           capture;
  logic           keep;
  logic           push;
  logic           filtered;
  logic           ovf_evt;
  logic           empty;
  logic           full;
  logic           clr_rdy_q;
  logic           ovfl_q;
  logic [7:0]     drop_cnt_q;

  assign keep     = (FILTER_EN == 0) || is_cmd(bus.uart_data);
  assign push     = capture && keep;
  assign filtered = capture && !keep;

  // Ingress next state: one capture per rdy assertion, wait for rdy to fall
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.uart_rdy) begin
          capture    = 1'b1;
          next_state = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!bus.uart_rdy) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Ingress state, UART clear pulse, sticky overflow and saturating drop count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clr_rdy_q  <= 1'b0;
      ovfl_q     <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      state     <= next_state;
      clr_rdy_q <= capture;
      if (bus.flush)    ovfl_q <= 1'b0;
      else if (ovf_evt) ovfl_q <= 1'b1;
      if (filtered && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  bt_fifo_core #(.DEPTH(DEPTH), .W(8)) u_core (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.clr_rx_rdy),
    .flush (bus.flush),
    .din   (bus.uart_data),
    .dout  (bus.rx_data),
    .full  (full),
    .empty (empty),
    .ovf   (ovf_evt)
  );

  assign bus.rx_rdy       = !empty;
  assign bus.uart_clr_rdy = clr_rdy_q;
  assign bus.ovfl         = ovfl_q;
  assign bus.drop_cnt     = drop_cnt_q;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_bt_cmd_fifo.sv
// Directed bench for bt_cmd_fifo: one filtering and one pass-all instance
// driven with identical stimulus; expected values are hand-computed.
module tb_bt_cmd_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   pulses = 0;

  always #5 clk = ~clk;

  bt_cmd_fifo_if if1();
  bt_cmd_fifo_if if0();

  bt_cmd_fifo #(.DEPTH(4), .FILTER_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bt_cmd_fifo #(.DEPTH(4), .FILTER_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  // Count cycles in which the filtering instance clears the UART
  always @(negedge clk) if (if1.uart_clr_rdy === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic c, input logic f);
    if1.uart_rdy = r; if1.uart_data = d; if1.clr_rx_rdy = c; if1.flush = f;
    if0.uart_rdy = r; if0.uart_data = d; if0.clr_rx_rdy = c; if0.flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic pop();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    // Reset values
    chk("rst_clr_rdy", {31'd0, if1.uart_clr_rdy}, 32'd0);
    chk("rst_rx_rdy",  {31'd0, if1.rx_rdy}, 32'd0);
    chk("rst_rx_data", {24'd0, if1.rx_data}, 32'h00);
    chk("rst_ovfl",    {31'd0, if1.ovfl}, 32'd0);
    chk("rst_drop",    {24'd0, if1.drop_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 1: single byte, one-cycle latency and one-cycle clear pulse
    drive(1'b1, 8'h67, 1'b0, 1'b0);
    tick();
    chk("t1_clr_pulse", {31'd0, if1.uart_clr_rdy}, 32'd1);
    chk("t1_rx_rdy",    {31'd0, if1.rx_rdy}, 32'd1);
    chk("t1_rx_data",   {24'd0, if1.rx_data}, 32'h67);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("t1_clr_end",   {31'd0, if1.uart_clr_rdy}, 32'd0);
    chk("t1_rx_hold",   {24'd0, if1.rx_data}, 32'h67);
    pop();
    chk("t1_popped",    {31'd0, if1.rx_rdy}, 32'd0);

    // 2: filter on vs off
    send(8'hAA); send(8'h41); send(8'h73);
    chk("t2_drop1",  {24'd0, if1.drop_cnt}, 32'd2);
    chk("t2_drop0",  {24'd0, if0.drop_cnt}, 32'd0);
    chk("t2_head1",  {24'd0, if1.rx_data}, 32'h73);
    chk("t2_head0a", {24'd0, if0.rx_data}, 32'hAA);
    pop();
    chk("t2_empty1", {31'd0, if1.rx_rdy}, 32'd0);
    chk("t2_head0b", {24'd0, if0.rx_data}, 32'h41);
    pop();
    chk("t2_uflow1", {31'd0, if1.rx_rdy}, 32'd0);
    chk("t2_head0c", {24'd0, if0.rx_data}, 32'h73);
    pop();
    chk("t2_empty0", {31'd0, if0.rx_rdy}, 32'd0);
    send(8'h67);
    chk("t2_after_uflow", {24'd0, if1.rx_data}, 32'h67);
    pop();

    // 3: overflow with no pops
    pulses = 0;
    send(8'h67); send(8'h73); send(8'h67); send(8'h73);
    chk("t3_no_ovfl_yet", {31'd0, if1.ovfl}, 32'd0);
    send(8'h67);
    chk("t3_ovfl",   {31'd0, if1.ovfl}, 32'd1);
    chk("t3_pulses", pulses, 32'd5);
    chk("t3_pop1", {24'd0, if1.rx_data}, 32'h67); pop();
    chk("t3_pop2", {24'd0, if1.rx_data}, 32'h73); pop();
    chk("t3_pop3", {24'd0, if1.rx_data}, 32'h67); pop();
    chk("t3_pop4", {24'd0, if1.rx_data}, 32'h73); pop();
    chk("t3_empty",  {31'd0, if1.rx_rdy}, 32'd0);
    chk("t3_sticky", {31'd0, if1.ovfl}, 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_flush_ovfl", {31'd0, if1.ovfl}, 32'd0);

    // 4: full plus simultaneous push/pop, across pointer wrap
    send(8'h67); pop();
    send(8'h67); send(8'h73); send(8'h67); send(8'h73);
    drive(1'b1, 8'h73, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_ovfl",  {31'd0, if1.ovfl}, 32'd0);
    chk("t4_head",  {24'd0, if1.rx_data}, 32'h73);
    tick();
    chk("t4_pop1", {24'd0, if1.rx_data}, 32'h73); pop();
    chk("t4_pop2", {24'd0, if1.rx_data}, 32'h67); pop();
    chk("t4_pop3", {24'd0, if1.rx_data}, 32'h73); pop();
    chk("t4_pop4", {24'd0, if1.rx_data}, 32'h73); pop();
    chk("t4_empty", {31'd0, if1.rx_rdy}, 32'd0);

    // 5: rdy held high captures once
    pulses = 0;
    drive(1'b1, 8'h67, 1'b0, 1'b0);
    repeat (10) tick();
    chk("t5_one_pulse", pulses, 32'd1);
    drive(1'b1, 8'h67, 1'b1, 1'b0);
    tick();
    chk("t5_one_entry", {31'd0, if1.rx_rdy}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h73, 1'b0, 1'b0);
    tick();
    chk("t5_second",      {24'd0, if1.rx_data}, 32'h73);
    chk("t5_second_rdy",  {31'd0, if1.rx_rdy}, 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("t5_two_pulses", pulses, 32'd2);
    pop();

    // 6: flush with 3 queued and ovfl set, then reset mid-capture
    send(8'h67); send(8'h73); send(8'h67); send(8'h67); send(8'h73);
    pop();
    chk("t6_pre_ovfl", {31'd0, if1.ovfl}, 32'd1);
    chk("t6_pre_rdy",  {31'd0, if1.rx_rdy}, 32'd1);
    drive(1'b1, 8'h73, 1'b1, 1'b1);
    tick();
    chk("t6_flush_rdy",   {31'd0, if1.rx_rdy}, 32'd0);
    chk("t6_flush_ovfl",  {31'd0, if1.ovfl}, 32'd0);
    chk("t6_flush_drop",  {24'd0, if1.drop_cnt}, 32'd2);
    chk("t6_flush_clr",   {31'd0, if1.uart_clr_rdy}, 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h67, 1'b0, 1'b0);
    tick();
    chk("t6_cap_rdy", {31'd0, if1.rx_rdy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_clr",  {31'd0, if1.uart_clr_rdy}, 32'd0);
    chk("t6_rst_rdy",  {31'd0, if1.rx_rdy}, 32'd0);
    chk("t6_rst_data", {24'd0, if1.rx_data}, 32'h00);
    chk("t6_rst_drop", {24'd0, if1.drop_cnt}, 32'd0);
    chk("t6_rst_ovfl", {31'd0, if1.ovfl}, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("t6_recap_rdy",  {31'd0, if1.rx_rdy}, 32'd1);
    chk("t6_recap_data", {24'd0, if1.rx_data}, 32'h67);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
